// File: rtl/latch_bank_wr_ctrl.sv
// latch_bank_wr_ctrl
// ------------------
// Write sequencer and arbiter for a bank of level-sensitive latches used as a
// small register file. One requester is granted at a time. The block then
// drives shared data and a one-hot latch enable through three phases:
//   SETUP : data stable, enable low (SETUP_CYC cycles)
//   OPEN  : one enable bit high    (OPEN_CYC cycles)
//   HOLD  : enable low, data held  (1 cycle)
// The enable is driven straight from flops, so the latch array never sees a
// decode glitch.
//
// Configuration macro:
//   LATCH_BANK_RR_EN  defined   -> round-robin arbitration. The search starts
//                                  at (last granted + 1) mod NREQ.
//                     undefined -> fixed priority. The lowest index wins.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]         per-requester write request
//   req_ready  out  [NREQ]         per-requester accept (at most one bit high)
//   req_addr   in   [NREQ*AW]      packed addresses, requester k at [k*AW +: AW]
//   req_data   in   [NREQ*DW]      packed data, requester k at [k*DW +: DW]
//   lat_d      out  [DW]           shared data to all latch D inputs
//   lat_en     out  [2**AW]        one-hot registered latch enables
//   busy       out                 high whenever the FSM is not in IDLE
//   grant_id   out  [$clog2(NREQ)] requester being (or last) serviced
module latch_bank_wr_ctrl #(
    parameter int NREQ      = 4,
    parameter int AW        = 3,
    parameter int DW        = 8,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [DW-1:0]            lat_d,
    output logic [(1<<AW)-1:0]       lat_en,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int GW    = $clog2(NREQ);
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_OPEN  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] OPEN_LOAD  = 4'(OPEN_CYC - 1);

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [AW-1:0]    cap_addr;
    logic [GW-1:0]    win;
    logic             any_valid;
    logic [DEPTH-1:0] en_dec;

`ifdef LATCH_BANK_RR_EN
    logic [GW-1:0] rr_ptr;

    // The loop walks from the farthest candidate down to the nearest. The
    // last valid hit it records is therefore the first one in round-robin
    // order, counting up from rr_ptr+1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        win       = '0;
        any_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[(int'(rr_ptr) + 1 + i) % NREQ]) begin
                win       = GW'((int'(rr_ptr) + 1 + i) % NREQ);
                any_valid = 1'b1;
            end
        end
    end

    // The pointer moves only on a handshake. It does not move just because
    // requests are pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= GW'(NREQ - 1);
        end else if (state == ST_IDLE && any_valid) begin
            rr_ptr <= win;
        end
    end
`else
    // Fixed priority. Scanning downward means the lowest valid index is the
    // last one written, so it wins.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win       = GW'(i);
                any_valid = 1'b1;
            end
        end
    end
`endif

    // Ready goes only to the winner, and only in IDLE. A handshake therefore
    // always lands on a valid requester.
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && any_valid) begin
            req_ready[win] = 1'b1;
        end
    end

    // Decode the captured address one cycle early so the decode result is
    // registered into lat_en.
    always_comb begin
        en_dec           = '0;
        en_dec[cap_addr] = 1'b1;
    end

    assign busy = (state != ST_IDLE);

    // The reset clears lat_en asynchronously. This closes every latch at once,
    // and no partial write resumes after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cap_addr <= '0;
            lat_d    <= '0;
            lat_en   <= '0;
            grant_id <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples values from before the edge.
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        cap_addr <= req_addr[int'(win)*AW +: AW];
                        lat_d    <= req_data[int'(win)*DW +: DW];
                        grant_id <= win;
                        cnt      <= SETUP_LOAD;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == 4'd0) begin
                        lat_en <= en_dec;
                        cnt    <= OPEN_LOAD;
                        state  <= ST_OPEN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_OPEN: begin
                    if (cnt == 4'd0) begin
                        lat_en <= '0;
                        state  <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Directed bench for latch_bank_wr_ctrl.
// u_dut  : default timing (SETUP_CYC=1, OPEN_CYC=1)
// u_dut2 : SETUP_CYC=3, OPEN_CYC=2
// Expected grant order depends on LATCH_BANK_RR_EN.
module tb_latch_bank_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  req_valid, req_ready;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic [7:0]  lat_d, lat_en;
    logic        busy;
    logic [1:0]  grant_id;

    logic [3:0]  req_valid2, req_ready2;
    logic [11:0] req_addr2;
    logic [31:0] req_data2;
    logic [7:0]  lat_d2, lat_en2;
    logic        busy2;
    logic [1:0]  grant_id2;

    int checks = 0;
    int errors = 0;
    int exp_g;

    always #5 clk = ~clk;

    latch_bank_wr_ctrl #(.NREQ(4), .AW(3), .DW(8), .SETUP_CYC(1), .OPEN_CYC(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .lat_d(lat_d), .lat_en(lat_en), .busy(busy), .grant_id(grant_id)
    );

    latch_bank_wr_ctrl #(.NREQ(4), .AW(3), .DW(8), .SETUP_CYC(3), .OPEN_CYC(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_addr(req_addr2), .req_data(req_data2),
        .lat_d(lat_d2), .lat_en(lat_en2), .busy(busy2), .grant_id(grant_id2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and stop just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [2:0] a, input logic [7:0] d);
        req_addr[k*3 +: 3] = a;
        req_data[k*8 +: 8] = d;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0; req_addr  = '0; req_data  = '0;
        req_valid2 = '0; req_addr2 = '0; req_data2 = '0;
        #12;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_lat_en", 32'(lat_en), 32'h0);
        check("rst_lat_d", 32'(lat_d), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_grant", 32'(grant_id), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write: requester 0 writes A5 to address 5.
        tick();
        req_valid = 4'b0001;
        set_req(0, 3'd5, 8'hA5);
        #1;
        check("w1_ready_T", 32'(req_ready), 32'h1);
        tick();                                     // T+1
        req_valid = '0;
        check("w1_lat_d_T1", 32'(lat_d), 32'hA5);
        check("w1_busy_T1", 32'(busy), 32'h1);
        check("w1_en_T1", 32'(lat_en), 32'h0);
        check("w1_grant_T1", 32'(grant_id), 32'h0);
        tick();                                     // T+2
        check("w1_en_T2", 32'(lat_en), 32'h20);
        check("w1_busy_T2", 32'(busy), 32'h1);
        tick();                                     // T+3
        check("w1_en_T3", 32'(lat_en), 32'h0);
        check("w1_busy_T3", 32'(busy), 32'h1);
        check("w1_lat_d_T3", 32'(lat_d), 32'hA5);
        tick();                                     // T+4
        check("w1_busy_T4", 32'(busy), 32'h0);

        // SETUP_CYC=3, OPEN_CYC=2: lat_en[0] high exactly at T+4 and T+5.
        tick();
        req_valid2 = 4'b0001;
        req_addr2[2:0] = 3'd0;
        req_data2[7:0] = 8'h3C;
        #1;
        check("w2_ready_T", 32'(req_ready2), 32'h1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) req_valid2 = '0;
            check($sformatf("w2_en_T%0d", k), 32'(lat_en2), (k == 4 || k == 5) ? 32'h1 : 32'h0);
            check($sformatf("w2_lat_d_T%0d", k), 32'(lat_d2), 32'h3C);
            check($sformatf("w2_busy_T%0d", k), 32'(busy2), (k <= 6) ? 32'h1 : 32'h0);
        end

        // Reset during OPEN: enable drops at once, and there is no pulse after release.
        tick();
        req_valid = 4'b0010;
        set_req(1, 3'd2, 8'h77);
        #1;
        check("rs_ready_T", 32'(req_ready), 32'h2);
        tick();                                     // T+1
        req_valid = '0;
        check("rs_grant_T1", 32'(grant_id), 32'h1);
        tick();                                     // T+2 (OPEN)
        check("rs_en_open", 32'(lat_en), 32'h04);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_en_async", 32'(lat_en), 32'h0);
        check("rs_busy_async", 32'(busy), 32'h0);
        check("rs_lat_d_async", 32'(lat_d), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rs_en_after%0d", k), 32'(lat_en), 32'h0);
            check($sformatf("rs_busy_after%0d", k), 32'(busy), 32'h0);
        end

        // All four requesters valid continuously. Requester k writes 10+k to address k.
        tick();
        for (int k = 0; k < 4; k++) set_req(k, 3'(k), 8'(8'h10 + k));
        req_valid = 4'b1111;
        #1;
        check("arb_ready_T", 32'(req_ready), 32'h1);
        for (int j = 0; j < 5; j++) begin
`ifdef LATCH_BANK_RR_EN
            exp_g = j % 4;
`else
            exp_g = 0;
`endif
            tick();
            check($sformatf("arb_grant%0d", j), 32'(grant_id), 32'(exp_g));
            check($sformatf("arb_lat_d%0d", j), 32'(lat_d), 32'(8'h10 + exp_g));
            tick();
            check($sformatf("arb_en%0d", j), 32'(lat_en), 32'(1 << exp_g));
            tick();
            tick();
        end
        req_valid = '0;
        tick();
        check("arb_idle", 32'(busy), 32'h0);

        // Withdrawn request: valid[2] pulses while busy and is never granted.
        req_valid = 4'b0001;
        set_req(0, 3'd1, 8'h55);
        #1;
        check("wd_ready_T", 32'(req_ready), 32'h1);
        tick();                                     // T+1
        req_valid = 4'b0100;
        set_req(2, 3'd6, 8'h99);
        #1;
        check("wd_ready_busy", 32'(req_ready), 32'h0);
        tick();                                     // T+2
        req_valid = '0;
        check("wd_en_T2", 32'(lat_en), 32'h02);
        check("wd_grant_T2", 32'(grant_id), 32'h0);
        tick();                                     // T+3
        check("wd_en_T3", 32'(lat_en), 32'h0);
        tick();                                     // T+4
        check("wd_busy_T4", 32'(busy), 32'h0);
        check("wd_ready_T4", 32'(req_ready), 32'h0);
        tick();                                     // T+5
        check("wd_busy_T5", 32'(busy), 32'h0);
        check("wd_en_T5", 32'(lat_en), 32'h0);
        check("wd_grant_T5", 32'(grant_id), 32'h0);
        check("wd_lat_d_T5", 32'(lat_d), 32'h55);

        // Back-to-back writes to address 7: data 11, then 22.
        tick();
        req_valid = 4'b1000;
        set_req(3, 3'd7, 8'h11);
        #1;
        check("bb_ready_T", 32'(req_ready), 32'h8);
        tick();                                     // T+1
        set_req(3, 3'd7, 8'h22);
        check("bb_lat_d_T1", 32'(lat_d), 32'h11);
        check("bb_grant_T1", 32'(grant_id), 32'h3);
        tick();                                     // T+2
        check("bb_en_T2", 32'(lat_en), 32'h80);
        check("bb_lat_d_T2", 32'(lat_d), 32'h11);
        tick();                                     // T+3
        check("bb_en_T3", 32'(lat_en), 32'h0);
        check("bb_lat_d_T3", 32'(lat_d), 32'h11);
        tick();                                     // T+4
        check("bb_ready_T4", 32'(req_ready), 32'h8);
        check("bb_lat_d_T4", 32'(lat_d), 32'h11);
        check("bb_busy_T4", 32'(busy), 32'h0);
        tick();                                     // T+5
        req_valid = '0;
        check("bb_lat_d_T5", 32'(lat_d), 32'h22);
        check("bb_en_T5", 32'(lat_en), 32'h0);
        tick();                                     // T+6
        check("bb_en_T6", 32'(lat_en), 32'h80);
        check("bb_lat_d_T6", 32'(lat_d), 32'h22);
        tick();                                     // T+7
        check("bb_en_T7", 32'(lat_en), 32'h0);
        tick();                                     // T+8
        check("bb_busy_T8", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/latch_bank_wr_ctrl.md
# latch_bank_wr_ctrl

Write sequencer and arbiter for a bank of level-sensitive latch primitives used as a small register file. Accepts write requests from NREQ requesters over valid/ready, grants one at a time, then drives shared data and a one-hot, registered, glitch-free latch-enable with guaranteed setup, open and hold phases. Sits between the requesters and the latch array; the latch array's enable inputs are driven only by this block.

## Interface
- NREQ, 4: number of requesters (2..8)
- AW, 3: word address width; bank depth = 2**AW
- DW, 8: data width per word
- SETUP_CYC, 1: cycles data is stable before enable opens (1..15)
- OPEN_CYC, 1: cycles enable is held high (1..15)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_addr  in  NREQ*AW  packed addresses, requester k at [k*AW +: AW]
- req_data  in  NREQ*DW  packed data, requester k at [k*DW +: DW]
- lat_d  out  DW  shared data to all latch D inputs
- lat_en  out  2**AW  one-hot latch enables (latch transparent when high)
- busy  out  1  high in any state other than IDLE
- grant_id  out  $clog2(NREQ)  index of requester being serviced

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD.
- IDLE: arbiter picks winner among req_valid; req_ready[winner]=1 combinationally, others 0. No valid -> req_ready all 0, stay IDLE.
- Handshake (req_valid[k] & req_ready[k]) captures addr, data, k into registers; next state SETUP.
- SETUP: lat_d = captured data, lat_en = 0; counts SETUP_CYC cycles -> OPEN.
- OPEN: lat_en[captured addr] = 1, all others 0; counts OPEN_CYC cycles -> HOLD.
- HOLD: lat_en = 0, lat_d unchanged; one cycle -> IDLE.
- lat_d changes only on handshake; never changes while any lat_en bit is high or in HOLD.
- lat_en is a flop output (no combinational decode at output), so no glitches.
- req_valid/addr/data changes after handshake are ignored until next IDLE.
- Requesters must hold req_valid, addr, data until accepted; dropping valid before ready is legal (request withdrawn, no write).
- Phase counter width 4 bits; loads SETUP_CYC-1 / OPEN_CYC-1 at phase entry, decrements to 0.

## Timing
- Reset values: req_ready=0 (combinational from state; IDLE with no valid), lat_en=0, lat_d=0, busy=0, grant_id=0, state=IDLE, RR pointer=NREQ-1.
- Reset asserted mid-operation: lat_en forced to 0 asynchronously; no partial write resumes after release.
- Handshake at cycle T: SETUP from T+1, lat_en high from T+1+SETUP_CYC for OPEN_CYC cycles, HOLD next, IDLE after.
- Per-write occupancy = SETUP_CYC+OPEN_CYC+2 cycles (4 with defaults); next handshake earliest at T+SETUP_CYC+OPEN_CYC+2.
- busy high from T+1 through HOLD inclusive; grant_id valid from T+1, held until next handshake.

## Configuration
- LATCH_BANK_RR_EN defined: round-robin arbitration; search starts at (last granted + 1) mod NREQ; pointer updates only on handshake.
- Undefined: fixed priority, lowest index wins; no pointer state.

## Test plan
- Reset then single write: req_valid=4'b0001, addr=5, data=8'hA5 -> ready[0] same cycle; lat_d=A5 at T+1; lat_en=8'b0010_0000 at T+2 only; busy T+1..T+3.
- SETUP_CYC=3, OPEN_CYC=2, one write addr 0 -> lat_en[0] high exactly cycles T+4,T+5; lat_d stable T+1..next handshake.
- All four requesters valid continuously, LATCH_BANK_RR_EN defined -> grants 0,1,2,3,0 every 4 cycles; undefined -> grants 0,0,0 while valid[0] held.
- rst_n low during OPEN -> lat_en=0 immediately (before next clk edge); after release, IDLE, no lat_en pulse without new handshake.
- Request withdrawn: valid[2] high then low before grant while busy -> no write to its address, no grant to 2.
- Back-to-back writes addr 7 then 7 with data 11/22 -> two distinct lat_en[7] pulses, lat_d 11 then 22, never changing while lat_en high.
